bpu_group_p: RTL and testbench

- Parametrised successor to the fixed 8-channel, 7x7 binary processing unit group.
- Holds K image row shift registers of ROW_W bits and one KxK binary weight kernel per channel.
- Runs an internal sequencer that slides the KxK window across every horizontal offset. For each offset it accumulates XNOR-popcount row by row, then emits one signed result per channel through a valid/ready output.
- Sits between the image/weight loader and the pooling/threshold stage of the BNN processor.

---
 rtl/bnn_pkg.sv | 27 ++
 rtl/bpu_group_p_if.sv | 61 ++++++
 rtl/bnn_xnor_popcnt.sv | 26 ++
 rtl/bpu_group_p.sv | 205 ++++++++++++++++++++
 tb/tb_bpu_group_p.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bnn_pkg.sv
// Shared types and width helpers for the binary processing unit group.
//   state_t  : sequencer states (IDLE / ACC / OUT)
//   cw()     : clog2-based width, never below 1 bit
//   acc_w()  : signed result width for a KxK kernel
//   result_t : signed result for the default kernel edge
package bnn_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    function automatic int unsigned cw(input int unsigned n);
        if (n <= 1) return 1;
        return $clog2(n);
    endfunction

    function automatic int unsigned acc_w(input int unsigned k);
        return $clog2(k * k + 1) + 1;
    endfunction

    localparam int unsigned K_DEF = 7;

    typedef logic signed [acc_w(K_DEF)-1:0] result_t;

endpackage

// File: rtl/bpu_group_p_if.sv
// Control, weight-load, image-load and result buses of the processing unit group.
//   slave  : the processing unit group
//   master : loader / sequencer client / downstream stage
interface bpu_group_p_if
    import bnn_pkg::*;
#(
    parameter int unsigned N_CH  = 8,
    parameter int unsigned K     = 7,
    parameter int unsigned ROW_W = 8
) ();

    localparam int unsigned N_OFF = ROW_W - K + 1;
    localparam int unsigned ACC_W = acc_w(K);
    localparam int unsigned KW    = cw(K + 1);
    localparam int unsigned CHW   = cw(N_CH);
    localparam int unsigned RW    = cw(K);
    localparam int unsigned OFFW  = cw(N_OFF);

    logic [KW-1:0]          k_eff;
    logic                   start;
    logic                   busy;
    logic                   done;

    logic                   wgt_valid;
    logic                   wgt_ready;
    logic [CHW-1:0]         wgt_ch;
    logic [RW-1:0]          wgt_row;
    logic [K-1:0]           wgt_data;

    logic                   img_valid;
    logic                   img_ready;
    logic [K-1:0]           img_data;

    logic                   out_valid;
    logic                   out_ready;
    logic [OFFW-1:0]        out_off;
    logic [N_CH*ACC_W-1:0]  out_data;

    modport slave (
        input  k_eff, start,
        output busy, done,
        input  wgt_valid, wgt_ch, wgt_row, wgt_data,
        output wgt_ready,
        input  img_valid, img_data,
        output img_ready,
        output out_valid, out_off, out_data,
        input  out_ready
    );

    modport master (
        output k_eff, start,
        input  busy, done,
        output wgt_valid, wgt_ch, wgt_row, wgt_data,
        input  wgt_ready,
        output img_valid, img_data,
        input  img_ready,
        input  out_valid, out_off, out_data,
        output out_ready
    );

endinterface

// File: rtl/bnn_xnor_popcnt.sv
// K-bit XNOR followed by population count (combinational).
//   a, b : operands
//   cnt  : number of equal bit positions, 0..K
module bnn_xnor_popcnt
    import bnn_pkg::*;
#(
    parameter int unsigned K = 7
) (
    input  logic [K-1:0]        a,
    input  logic [K-1:0]        b,
    output logic [cw(K+1)-1:0]  cnt
);

    localparam int unsigned CNT_W = cw(K + 1);

    logic [K-1:0] xn;

    always_comb begin
        xn  = ~(a ^ b);
        cnt = '0;
        for (int i = 0; i < K; i++) begin
            cnt = cnt + CNT_W'(xn[i]);
        end
    end

endmodule

// File: rtl/bpu_group_p.sv
// Binary processing unit group: K image row shift registers, one KxK binary
// kernel per channel, and a sequencer that slides the window over every
// horizontal offset, emitting one signed XNOR-popcount result per channel.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : k_eff/start/busy/done control, wgt_* and img_* load
//              handshakes, out_* result handshake
module bpu_group_p
    import bnn_pkg::*;
#(
    parameter int unsigned N_CH  = 8,
    parameter int unsigned K     = 7,
    parameter int unsigned ROW_W = 8
) (
    input  logic         clk,
    input  logic         rst,
    bpu_group_p_if.slave bus
);

    localparam int unsigned N_OFF = ROW_W - K + 1;
    localparam int unsigned ACC_W = acc_w(K);
    localparam int unsigned KW    = cw(K + 1);
    localparam int unsigned RW    = cw(K);
    localparam int unsigned OFFW  = cw(N_OFF);
    localparam int unsigned PW    = cw(K + 1);

    state_t                 state;
    state_t                 state_d;

    logic [KW-1:0]          k_lat;
    logic [KW-1:0]          k_sel;
    logic [KW-1:0]          row_idx;
    logic [RW-1:0]          rd_row;
    logic [OFFW-1:0]        off;

    logic [ROW_W-1:0]       img_row [K];
    logic [K-1:0]           kern    [N_CH][K];
    logic [ACC_W-1:0]       acc     [N_CH];
    logic [ACC_W-1:0]       acc_nxt [N_CH];
    logic [PW-1:0]          pop     [N_CH];

    logic [K-1:0]           win;
    logic [ACC_W-1:0]       bias;
    logic [N_CH*ACC_W-1:0]  res;

    logic                   out_valid_q;
    logic [OFFW-1:0]        out_off_q;
    logic [N_CH*ACC_W-1:0]  out_data_q;
    logic                   done_q;

    logic                   idle;
    logic                   wgt_hs;
    logic                   img_hs;
    logic                   last_off;
    logic                   start_pass;
    logic                   acc_clr;
    logic                   acc_en;
    logic                   out_load;
    logic                   out_hs;

    assign idle          = (state == IDLE);
    assign bus.wgt_ready = idle;
    assign bus.img_ready = idle;
    assign bus.busy      = !idle;
    assign bus.done      = done_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_off   = out_off_q;
    assign bus.out_data  = out_data_q;

    assign wgt_hs   = bus.wgt_valid && idle;
    assign img_hs   = bus.img_valid && idle;
    assign last_off = (off == OFFW'(N_OFF - 1));

    // Zero or oversized k_eff means "use the full kernel".
    always_comb begin
        if (bus.k_eff == '0 || 32'(bus.k_eff) > K) k_sel = KW'(K);
        else                                       k_sel = bus.k_eff;
    end

    // row_idx reaches k_lat after the final ACC cycle; keep the read index in range.
    assign rd_row = (32'(row_idx) < K) ? RW'(row_idx) : '0;
    assign win    = img_row[rd_row][off +: K];

    // One XNOR-popcount lane per channel on the current window row.
    for (genvar c = 0; c < N_CH; c++) begin : g_lane
        bnn_xnor_popcnt #(.K(K)) u_xp (
            .a   (win),
            .b   (kern[c][rd_row]),
            .cnt (pop[c])
        );
    end

    // Result = matches - mismatches = 2*matches - k_eff*K, taken from the
    // accumulator value that includes the final row; modulo-2^ACC_W is exact
    // because the true value lies within -K*K..+K*K.
    assign bias = ACC_W'(k_lat) * ACC_W'(K);

    always_comb begin
        res = '0;
        for (int c = 0; c < N_CH; c++) begin
            acc_nxt[c]                = acc[c] + ACC_W'(pop[c]);
            res[c*ACC_W +: ACC_W]     = (acc_nxt[c] << 1) - bias;
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // Sequencer next state and datapath controls.
    always_comb begin
        state_d    = state;
        start_pass = 1'b0;
        acc_clr    = 1'b0;
        acc_en     = 1'b0;
        out_load   = 1'b0;
        out_hs     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    start_pass = 1'b1;
                    acc_clr    = 1'b1;
                    state_d    = ACC;
                end
            end
            ACC: begin
                acc_en = 1'b1;
                if (row_idx == k_lat - KW'(1)) begin
                    out_load = 1'b1;
                    state_d  = OUT;
                end
            end
            OUT: begin
                if (bus.out_ready) begin
                    out_hs = 1'b1;
                    if (last_off) begin
                        state_d = IDLE;
                    end else begin
                        acc_clr = 1'b1;
                        state_d = ACC;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Image rows, kernels, accumulators and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < K; r++) img_row[r] <= '0;
            for (int c = 0; c < N_CH; c++) begin
                for (int r = 0; r < K; r++) kern[c][r] <= '0;
                acc[c] <= '0;
            end
            k_lat       <= '0;
            row_idx     <= '0;
            off         <= '0;
            out_valid_q <= 1'b0;
            out_off_q   <= '0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;

            // Out-of-range kernel rows/channels are accepted and dropped.
            if (wgt_hs && 32'(bus.wgt_row) < K && 32'(bus.wgt_ch) < N_CH) begin
                kern[bus.wgt_ch][bus.wgt_row] <= bus.wgt_data;
            end

            if (img_hs) begin
                for (int r = 0; r < K; r++) begin
                    img_row[r] <= {img_row[r][ROW_W-2:0], bus.img_data[r]};
                end
            end

            if (start_pass) begin
                k_lat <= k_sel;
                off   <= '0;
            end

            if (acc_clr) begin
                for (int c = 0; c < N_CH; c++) acc[c] <= '0;
                row_idx <= '0;
            end else if (acc_en) begin
                for (int c = 0; c < N_CH; c++) acc[c] <= acc_nxt[c];
                row_idx <= row_idx + KW'(1);
            end

            if (out_load) begin
                out_valid_q <= 1'b1;
                out_off_q   <= off;
                out_data_q  <= res;
            end

            if (out_hs) begin
                out_valid_q <= 1'b0;
                if (last_off) done_q <= 1'b1;
                else          off    <= off + OFFW'(1);
            end
        end
    end

endmodule

// File: tb/tb_bpu_group_p.sv
// Self-checking bench for bpu_group_p: table of uniform kernel/image passes,
// a per-channel kernel pass, an output-stall sequence and a mid-pass reset.
// Expected results are queued when a pass starts and checked on each output
// handshake.
module tb_bpu_group_p;
    import bnn_pkg::*;

    localparam int unsigned N_CH  = 8;
    localparam int unsigned K     = 7;
    localparam int unsigned ROW_W = 8;
    localparam int unsigned N_OFF = ROW_W - K + 1;
    localparam int unsigned ACC_W = acc_w(K);
    localparam int unsigned KW    = cw(K + 1);
    localparam int unsigned CHW   = cw(N_CH);
    localparam int unsigned RW    = cw(K);
    localparam int unsigned OFFW  = cw(N_OFF);
    localparam int unsigned DW    = N_CH * ACC_W;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    bpu_group_p_if #(.N_CH(N_CH), .K(K), .ROW_W(ROW_W)) bus ();

    bpu_group_p #(.N_CH(N_CH), .K(K), .ROW_W(ROW_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [OFFW-1:0] off;
        logic [DW-1:0]   data;
    } exp_t;

    typedef struct {
        logic [K-1:0] kern;   // every kernel row of every channel
        logic [K-1:0] col;    // every image column
        int           k;      // k_eff applied
        int           res;    // per-channel result at both offsets
    } vec_t;

    exp_t sbq [$];
    exp_t mon_e;
    vec_t tab [7];

    int vectors     = 0;
    int miscompares = 0;
    int lat;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    function automatic logic [DW-1:0] pack_all(input int v);
        logic [DW-1:0] r;
        for (int c = 0; c < N_CH; c++) r[c*ACC_W +: ACC_W] = ACC_W'(v);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_w(input int ch, input int row, input logic [K-1:0] d);
        bus.wgt_valid = 1'b1;
        bus.wgt_ch    = CHW'(ch);
        bus.wgt_row   = RW'(row);
        bus.wgt_data  = d;
        tick();
        bus.wgt_valid = 1'b0;
    endtask

    task automatic load_all_kern(input logic [K-1:0] d);
        for (int c = 0; c < N_CH; c++)
            for (int r = 0; r < K; r++) load_w(c, r, d);
    endtask

    task automatic load_img(input logic [K-1:0] col, input int n);
        for (int i = 0; i < n; i++) begin
            bus.img_valid = 1'b1;
            bus.img_data  = col;
            tick();
            bus.img_valid = 1'b0;
        end
    endtask

    task automatic push_pass(input logic [DW-1:0] d);
        for (int o = 0; o < N_OFF; o++) begin
            exp_t e;
            e.off  = OFFW'(o);
            e.data = d;
            sbq.push_back(e);
        end
    endtask

    task automatic kick(input int k);
        bus.k_eff = KW'(k);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // Counts clock edges from the start edge until out_valid is seen; returns at a negedge.
    task automatic wait_valid(output int n);
        n = 1;
        forever begin
            @(negedge clk);
            if (bus.out_valid || n >= 60) break;
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic wait_done(input string tag);
        logic got;
        got = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (bus.done) begin
                got = 1'b1;
                break;
            end
        end
        chk({tag, "_done_seen"}, 64'(got), 64'd1);
        @(negedge clk);
        chk({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
        chk({tag, "_idle_after"}, 64'(bus.busy), 64'd0);
        chk({tag, "_sb_empty"},   64'(sbq.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_lat(input int k);
        if (k == 0 || k > K) return K + 1;
        return k + 1;
    endfunction

    initial begin
        tab[0] = '{7'h7F, 7'h7F, 7,  49};
        tab[1] = '{7'h7F, 7'h00, 7, -49};
        tab[2] = '{7'h7F, 7'h07, 3,  21};
        tab[3] = '{7'h00, 7'h00, 0,  49};
        tab[4] = '{7'h00, 7'h7F, 1,  -7};
        tab[5] = '{7'h55, 7'h7F, 7,   7};
        tab[6] = '{7'h7F, 7'h55, 5,   7};

        rst           = 1'b1;
        bus.k_eff     = '0;
        bus.start     = 1'b0;
        bus.wgt_valid = 1'b0;
        bus.wgt_ch    = '0;
        bus.wgt_row   = '0;
        bus.wgt_data  = '0;
        bus.img_valid = 1'b0;
        bus.img_data  = '0;
        bus.out_ready = 1'b1;

        // Output-handshake monitor feeding the scoreboard.
        fork
            forever begin
                @(negedge clk);
                if (!rst && bus.out_valid && bus.out_ready) begin
                    if (sbq.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_output: got off %0d data %0h want none",
                                 bus.out_off, bus.out_data);
                    end else begin
                        mon_e = sbq.pop_front();
                        chk("out_off",  64'(bus.out_off),  64'(mon_e.off));
                        chk("out_data", 64'(bus.out_data), 64'(mon_e.data));
                    end
                end
            end
        join_none

        #3;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_busy",      64'(bus.busy),      64'd0);
        chk("rst_done",      64'(bus.done),      64'd0);
        chk("rst_out_data",  64'(bus.out_data),  64'd0);
        chk("rst_out_off",   64'(bus.out_off),   64'd0);
        chk("rst_wgt_ready", 64'(bus.wgt_ready), 64'd1);
        chk("rst_img_ready", 64'(bus.img_ready), 64'd1);
        tick();
        rst = 1'b0;
        tick();

        // Uniform kernel/image passes.
        foreach (tab[i]) begin
            load_all_kern(tab[i].kern);
            load_img(tab[i].col, ROW_W);
            push_pass(pack_all(tab[i].res));
            kick(tab[i].k);
            wait_valid(lat);
            chk($sformatf("tab%0d_latency", i), 64'(lat), 64'(exp_lat(tab[i].k)));
            wait_done($sformatf("tab%0d", i));
        end

        // Even channels: row0 all ones vs all-zero image -> 7 mismatches (+35); odd: +49.
        begin
            logic [DW-1:0] pc;
            for (int c = 0; c < N_CH; c++) begin
                for (int r = 0; r < K; r++)
                    load_w(c, r, (r == 0 && c % 2 == 0) ? 7'h7F : 7'h00);
                pc[c*ACC_W +: ACC_W] = (c % 2 == 0) ? ACC_W'(35) : ACC_W'(49);
            end
            load_img(7'h00, ROW_W);
            push_pass(pc);
            kick(7);
            wait_valid(lat);
            chk("perch_latency", 64'(lat), 64'd8);
            wait_done("perch");
        end

        // Output stall: busy blocks loads, start and k_eff changes.
        load_all_kern(7'h7F);
        load_w(0, 7, 7'h00);
        load_img(7'h7F, ROW_W);
        bus.out_ready = 1'b0;
        push_pass(pack_all(49));
        kick(7);
        wait_valid(lat);
        chk("stall_latency", 64'(lat), 64'd8);
        for (int i = 0; i < 5; i++) begin
            chk("stall_out_valid", 64'(bus.out_valid), 64'd1);
            chk("stall_out_data",  64'(bus.out_data),  64'(pack_all(49)));
            chk("stall_out_off",   64'(bus.out_off),   64'd0);
            chk("stall_img_ready", 64'(bus.img_ready), 64'd0);
            chk("stall_busy",      64'(bus.busy),      64'd1);
            @(posedge clk);
            #1;
            bus.start     = 1'b1;
            bus.k_eff     = KW'(3);
            bus.img_valid = 1'b1;
            bus.img_data  = 7'h00;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus.start     = 1'b0;
        bus.img_valid = 1'b0;
        bus.out_ready = 1'b1;
        wait_done("stall");

        // Reset in the middle of an accumulation.
        load_img(7'h7F, ROW_W);
        kick(7);
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_busy",      64'(bus.busy),      64'd0);
        chk("midrst_done",      64'(bus.done),      64'd0);
        chk("midrst_out_data",  64'(bus.out_data),  64'd0);
        chk("midrst_out_off",   64'(bus.out_off),   64'd0);
        chk("midrst_wgt_ready", 64'(bus.wgt_ready), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        load_img(7'h00, ROW_W);
        push_pass(pack_all(49));
        kick(7);
        wait_valid(lat);
        chk("postrst_latency", 64'(lat), 64'd8);
        wait_done("postrst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
